dl_region_router: RTL and testbench

- Parametrised successor to the fixed two-way download address remap: routes HPS ioctl download bytes into one of NREG memory regions, selected by ioctl_index.
- Each region has its own base, size limit and index match.
- Buffers writes in a small FIFO with a valid/ready memory handshake and drives ioctl_wait for back-pressure.
- Sits between hps_io and the core RAM/ROM write port. Also generates the CPU reset request used while a boot image loads.

---
 rtl/dl_router_pkg.sv | 53 +++++
 rtl/dl_fifo.sv | 54 +++++
 rtl/dl_region_router.sv | 199 +++++++++++++++++++
 tb/tb_dl_region_router.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_router_pkg.sv
// Download router shared types.
// Region tables are packed vectors sliced by region.
package dl_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  localparam int PKW = 256;
  localparam int SLW = 64;

  function automatic logic [SLW-1:0] field(
    input logic [PKW-1:0] vec,
    input int             w,
    input int             r
  );
    logic [PKW-1:0] sh;
    logic [SLW-1:0] f;
    sh = vec >> (w * r);
    for (int i = 0; i < SLW; i++) begin
      f[i] = (i < w) ? sh[i] : 1'b0;
    end
    return f;
  endfunction

  function automatic logic [SLW-1:0] reg_idx(
    input logic [PKW-1:0] vec,
    input int             w,
    input int             r
  );
    return field(vec, w, r);
  endfunction

  function automatic logic [SLW-1:0] reg_base(
    input logic [PKW-1:0] vec,
    input int             w,
    input int             r
  );
    return field(vec, w, r);
  endfunction

  function automatic logic [SLW-1:0] reg_size(
    input logic [PKW-1:0] vec,
    input int             w,
    input int             r
  );
    return field(vec, w, r);
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push while full is taken only when a pop happens.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dl_region_router.sv
// Routes ioctl download bytes into one of NREG regions.
// Buffered through a FIFO with valid/ready to memory.
module dl_region_router #(
  parameter int NREG   = 4,
  parameter int IDX_W  = 8,
  parameter int IN_AW  = 14,
  parameter int OUT_AW = 25,
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter logic [NREG*IDX_W-1:0] REG_IDX =
    {8'd3, 8'd2, 8'd1, 8'd0},
  parameter logic [NREG*OUT_AW-1:0] REG_BASE =
    {25'h30000, 25'h20000, 25'h10000, 25'h0},
  parameter logic [NREG*(IN_AW+1)-1:0] REG_SIZE =
    {4{15'h4000}},
  parameter logic [NREG-1:0] RST_MASK = 4'b0001
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [IN_AW-1:0]         ioctl_addr,
  input  logic [DW-1:0]            ioctl_dout,
  input  logic [IDX_W-1:0]         ioctl_index,
  output logic                     ioctl_wait,
  output logic [OUT_AW-1:0]        mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     cpu_reset_req,
  output logic                     load_done,
  output logic [$clog2(NREG)-1:0]  done_region,
  output logic [IN_AW:0]           bytes_loaded,
  output logic                     err_unmapped,
  output logic                     err_overflow
);

  import dl_router_pkg::*;

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = OUT_AW + DW;

  state_t state;
  state_t nstate;

  logic          dl_q;
  logic          rise;
  logic          enter;
  logic          hit_c;
  logic          hit_q;
  logic [RW-1:0] reg_c;
  logic [RW-1:0] reg_q;

  logic [IDX_W-1:0]  idx_a  [NREG];
  logic [OUT_AW-1:0] base_a [NREG];
  logic [IN_AW:0]    size_a [NREG];

  logic              wr_ld;
  logic              oob;
  logic              push;
  logic              pop;
  logic              drop_unm;
  logic              drop_ovf;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [FW-1:0]     rdata;
  logic [OUT_AW-1:0] waddr;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    assign idx_a[g]  = IDX_W'(reg_idx(PKW'(REG_IDX), IDX_W, g));
    assign base_a[g] = OUT_AW'(reg_base(PKW'(REG_BASE), OUT_AW, g));
    assign size_a[g] = (IN_AW+1)'(reg_size(PKW'(REG_SIZE), IN_AW + 1, g));
  end

  // lowest-numbered matching region wins
  always_comb begin
    hit_c = 1'b0;
    reg_c = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (ioctl_index == idx_a[r]) begin
        hit_c = 1'b1;
        reg_c = RW'(r);
      end
    end
  end

  assign rise = ioctl_download && !dl_q;

  // next state and load-entry strobe
  always_comb begin
    nstate = state;
    enter  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          nstate = LOAD;
          enter  = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) nstate = DRAIN;
      end
      DRAIN: begin
        if (empty) nstate = DONE;
      end
      DONE: begin
        if (ioctl_download) begin
          nstate = LOAD;
          enter  = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  assign pop      = mem_valid && mem_ready;
  assign wr_ld    = ioctl_wr && (state == LOAD);
  assign oob      = {1'b0, ioctl_addr} >= size_a[reg_q];
  assign push     = wr_ld && hit_q && !oob && (!full || pop);
  assign drop_unm = wr_ld && !hit_q;
  assign drop_ovf = wr_ld && hit_q && (oob || (full && !pop));
  assign waddr    = base_a[reg_q] + OUT_AW'(ioctl_addr);

  dl_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (push),
    .wdata ({waddr, ioctl_dout}),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign mem_valid = !empty;
  assign {mem_addr, mem_data} = mem_valid ? rdata : '0;
  assign load_done = (state == DONE);

  // state register and download edge history
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dl_q  <= 1'b0;
    end else begin
      state <= nstate;
      dl_q  <= ioctl_download;
    end
  end

  // per-load region latch, status and cpu hold
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      reg_q         <= '0;
      hit_q         <= 1'b0;
      err_unmapped  <= 1'b0;
      err_overflow  <= 1'b0;
      bytes_loaded  <= '0;
      cpu_reset_req <= 1'b0;
    end else if (enter) begin
      reg_q         <= reg_c;
      hit_q         <= hit_c;
      err_unmapped  <= 1'b0;
      err_overflow  <= 1'b0;
      bytes_loaded  <= '0;
      cpu_reset_req <= hit_c && RST_MASK[reg_c];
    end else begin
      if (drop_unm) err_unmapped <= 1'b1;
      if (drop_ovf) err_overflow <= 1'b1;
      if (push && (bytes_loaded != '1)) begin
        bytes_loaded <= bytes_loaded + 1'b1;
      end
      if (state == DONE) cpu_reset_req <= 1'b0;
    end
  end

  // completion region and registered back-pressure
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      done_region <= '0;
      ioctl_wait  <= 1'b0;
    end else begin
      if ((state == DRAIN) && (nstate == DONE)) begin
        done_region <= reg_q;
      end
      ioctl_wait <= (count >= CW'(DEPTH - 1)) ||
                    (((state == DRAIN) || (state == DONE)) &&
                     ioctl_download);
    end
  end

endmodule

// File: tb/tb_dl_region_router.sv
// Testbench for dl_region_router.
// Scenario tasks plus a per-cycle reference model.
module tb_dl_region_router;
  import dl_router_pkg::*;

  localparam int NREG   = 4;
  localparam int IDX_W  = 8;
  localparam int IN_AW  = 15;
  localparam int OUT_AW = 25;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [IN_AW-1:0]  ioctl_addr = '0;
  logic [DW-1:0]     ioctl_dout = '0;
  logic [IDX_W-1:0]  ioctl_index = '0;
  logic              ioctl_wait;
  logic [OUT_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_valid;
  logic              mem_ready = 1'b1;
  logic              cpu_reset_req;
  logic              load_done;
  logic [1:0]        done_region;
  logic [IN_AW:0]    bytes_loaded;
  logic              err_unmapped;
  logic              err_overflow;

  int tests = 0;
  int fails = 0;
  int nwr   = 0;

  int idx_tab  [NREG] = '{0, 1, 2, 3};
  int base_tab [NREG] = '{'h0, 'h10000, 'h20000, 'h30000};
  int size_tab [NREG] = '{'h4000, 'h4000, 'h4000, 'h4000};
  bit rm_tab   [NREG] = '{1'b1, 1'b0, 1'b0, 1'b0};

  int   m_phase = P_IDLE;
  int   m_reg = 0;
  int   m_bytes = 0;
  int   m_done_reg = 0;
  bit   m_dl = 0;
  bit   m_hit = 0;
  bit   m_unm = 0;
  bit   m_ovf = 0;
  bit   m_crr = 0;
  bit   m_wait = 0;
  logic [OUT_AW+DW-1:0] sbq [$];

  always #5 clk = ~clk;

  dl_region_router #(
    .NREG     (NREG),
    .IDX_W    (IDX_W),
    .IN_AW    (IN_AW),
    .OUT_AW   (OUT_AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .REG_IDX  ({8'd3, 8'd2, 8'd1, 8'd0}),
    .REG_BASE ({25'h30000, 25'h20000, 25'h10000, 25'h0}),
    .REG_SIZE ({4{16'h4000}}),
    .RST_MASK (4'b0001)
  ) dut (
    .clk_sys        (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .cpu_reset_req  (cpu_reset_req),
    .load_done      (load_done),
    .done_region    (done_region),
    .bytes_loaded   (bytes_loaded),
    .err_unmapped   (err_unmapped),
    .err_overflow   (err_overflow)
  );

  function automatic void m_enter(input int idx);
    m_hit = 0;
    m_reg = 0;
    for (int r = 0; r < NREG; r++) begin
      if (!m_hit && idx_tab[r] == idx) begin
        m_hit = 1;
        m_reg = r;
      end
    end
    m_unm   = 0;
    m_ovf   = 0;
    m_bytes = 0;
    m_crr   = m_hit && rm_tab[m_reg];
    m_phase = P_LOAD;
  endfunction

  // reference model: check current outputs, then predict next edge
  always @(negedge clk) begin
    int occ;
    bit hs;
    bit nwait;
    logic [OUT_AW+DW-1:0] e;
    if (!reset_n) begin
      m_phase = P_IDLE; m_reg = 0; m_bytes = 0; m_done_reg = 0;
      m_dl = 0; m_hit = 0; m_unm = 0; m_ovf = 0; m_crr = 0; m_wait = 0;
      sbq.delete();
    end else begin
      occ = sbq.size();
      tests++;
      if (load_done !== (m_phase == P_DONE)) begin
        fails++;
        $display("FAIL mdl_load_done got=%b want=%b t=%0t",
                 load_done, m_phase == P_DONE, $time);
      end
      tests++;
      if (cpu_reset_req !== m_crr) begin
        fails++;
        $display("FAIL mdl_cpu_reset got=%b want=%b t=%0t",
                 cpu_reset_req, m_crr, $time);
      end
      tests++;
      if (err_unmapped !== m_unm) begin
        fails++;
        $display("FAIL mdl_err_unmapped got=%b want=%b t=%0t",
                 err_unmapped, m_unm, $time);
      end
      tests++;
      if (err_overflow !== m_ovf) begin
        fails++;
        $display("FAIL mdl_err_overflow got=%b want=%b t=%0t",
                 err_overflow, m_ovf, $time);
      end
      tests++;
      if (bytes_loaded !== 16'(m_bytes)) begin
        fails++;
        $display("FAIL mdl_bytes got=%0d want=%0d t=%0t",
                 bytes_loaded, m_bytes, $time);
      end
      tests++;
      if (done_region !== 2'(m_done_reg)) begin
        fails++;
        $display("FAIL mdl_done_region got=%0d want=%0d t=%0t",
                 done_region, m_done_reg, $time);
      end
      tests++;
      if (ioctl_wait !== m_wait) begin
        fails++;
        $display("FAIL mdl_wait got=%b want=%b t=%0t",
                 ioctl_wait, m_wait, $time);
      end
      tests++;
      if (mem_valid !== (occ != 0)) begin
        fails++;
        $display("FAIL mdl_mem_valid got=%b want=%b t=%0t",
                 mem_valid, occ != 0, $time);
      end
      hs = (mem_valid === 1'b1) && mem_ready && (occ > 0);
      if (hs) begin
        e = sbq.pop_front();
        nwr++;
        tests++;
        if ({mem_addr, mem_data} !== e) begin
          fails++;
          $display("FAIL mdl_mem_write got=%h/%h want=%h/%h t=%0t",
                   mem_addr, mem_data, e[DW+:OUT_AW], e[DW-1:0], $time);
        end
      end
      nwait = (occ >= DEPTH - 1) ||
              ((m_phase == P_DRAIN || m_phase == P_DONE) && ioctl_download);
      case (m_phase)
        P_IDLE: begin
          if (ioctl_download && !m_dl) m_enter(int'(ioctl_index));
        end
        P_LOAD: begin
          if (ioctl_wr) begin
            if (!m_hit) m_unm = 1;
            else if (int'(ioctl_addr) >= size_tab[m_reg]) m_ovf = 1;
            else if (occ - int'(hs) >= DEPTH) m_ovf = 1;
            else begin
              sbq.push_back({25'(base_tab[m_reg] + int'(ioctl_addr)),
                             ioctl_dout});
              if (m_bytes < (1 << (IN_AW + 1)) - 1) m_bytes++;
            end
          end
          if (!ioctl_download) m_phase = P_DRAIN;
        end
        P_DRAIN: begin
          if (occ == 0) begin
            m_phase    = P_DONE;
            m_done_reg = m_reg;
          end
        end
        default: begin
          if (ioctl_download) m_enter(int'(ioctl_index));
          else begin
            m_phase = P_IDLE;
            m_crr   = 0;
          end
        end
      endcase
      m_wait = nwait;
      m_dl   = ioctl_download;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [IN_AW-1:0] a, input logic [DW-1:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    cyc();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load(input int idx);
    ioctl_index    = 8'(idx);
    ioctl_download = 1'b1;
    cyc();
  endtask

  task automatic end_load(output bit seen, output logic [1:0] dr,
                          output logic [IN_AW:0] bl);
    seen = 0;
    dr   = '0;
    bl   = '0;
    ioctl_download = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        seen = 1;
        dr   = done_region;
        bl   = bytes_loaded;
        break;
      end
    end
    cyc();
  endtask

  task automatic test_reset();
    tests++;
    if ({ioctl_wait, mem_valid, cpu_reset_req, load_done,
         err_unmapped, err_overflow} !== 6'b0 ||
        mem_addr !== '0 || mem_data !== '0 ||
        done_region !== '0 || bytes_loaded !== '0) begin
      fails++;
      $display("FAIL reset_outputs wait=%b valid=%b crr=%b done=%b addr=%h bytes=%0d",
               ioctl_wait, mem_valid, cpu_reset_req, load_done,
               mem_addr, bytes_loaded);
    end
  endtask

  task automatic test_basic_load();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    int w0;
    w0 = nwr;
    start_load(0);
    #1;
    tests++;
    if (cpu_reset_req !== 1'b1) begin
      fails++;
      $display("FAIL basic_crr_entry got=%b want=1", cpu_reset_req);
    end
    for (int i = 0; i < 16; i++) do_wr(15'(i), 8'($urandom));
    end_load(seen, dr, bl);
    tests++;
    if (!seen || dr !== 2'd0 || bl !== 16'd16) begin
      fails++;
      $display("FAIL basic_done seen=%0d region=%0d bytes=%0d want 1/0/16",
               seen, dr, bl);
    end
    tests++;
    if (cpu_reset_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_crr_clear got=%b want=0", cpu_reset_req);
    end
    tests++;
    if (nwr - w0 != 16) begin
      fails++;
      $display("FAIL basic_writes got=%0d want=16", nwr - w0);
    end
  endtask

  task automatic test_single_write();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    start_load(2);
    ioctl_wr   = 1'b1;
    ioctl_addr = 15'h0005;
    ioctl_dout = 8'hA5;
    cyc();
    ioctl_wr = 1'b0;
    #1;
    tests++;
    if (mem_valid !== 1'b1 || mem_addr !== 25'h20005 || mem_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_write valid=%b addr=%h data=%h want 1/20005/a5",
               mem_valid, mem_addr, mem_data);
    end
    tests++;
    if (cpu_reset_req !== 1'b0) begin
      fails++;
      $display("FAIL single_crr got=%b want=0", cpu_reset_req);
    end
    end_load(seen, dr, bl);
    tests++;
    if (!seen || dr !== 2'd2 || bl !== 16'd1) begin
      fails++;
      $display("FAIL single_done seen=%0d region=%0d bytes=%0d want 1/2/1",
               seen, dr, bl);
    end
  endtask

  task automatic test_unmapped();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    int w0;
    w0 = nwr;
    start_load(7);
    for (int i = 0; i < 4; i++) do_wr(15'(i), 8'($urandom));
    end_load(seen, dr, bl);
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL unmapped_done seen=0 want=1");
    end
    tests++;
    if (err_unmapped !== 1'b1 || bytes_loaded !== '0 || nwr != w0) begin
      fails++;
      $display("FAIL unmapped_status err=%b bytes=%0d writes=%0d want 1/0/0",
               err_unmapped, bytes_loaded, nwr - w0);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    start_load(1);
    do_wr(15'h4000, 8'h11);
    #1;
    tests++;
    if (err_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag got=%b want=1", err_overflow);
    end
    do_wr(15'h3FFF, 8'h5C);
    #1;
    tests++;
    if (mem_valid !== 1'b1 || mem_addr !== 25'h13FFF || mem_data !== 8'h5C) begin
      fails++;
      $display("FAIL overflow_edge valid=%b addr=%h data=%h want 1/13fff/5c",
               mem_valid, mem_addr, mem_data);
    end
    end_load(seen, dr, bl);
    tests++;
    if (!seen || dr !== 2'd1 || bl !== 16'd1) begin
      fails++;
      $display("FAIL overflow_done seen=%0d region=%0d bytes=%0d want 1/1/1",
               seen, dr, bl);
    end
  endtask

  task automatic test_stall();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    int w0;
    w0 = nwr;
    mem_ready = 1'b0;
    start_load(3);
    for (int i = 0; i < 6; i++) do_wr(15'(i), 8'($urandom));
    #1;
    tests++;
    if (ioctl_wait !== 1'b1 || err_overflow !== 1'b1) begin
      fails++;
      $display("FAIL stall_full wait=%b ovf=%b want 1/1", ioctl_wait, err_overflow);
    end
    repeat (4) cyc();
    tests++;
    if (mem_valid !== 1'b1 || mem_addr !== 25'h30000) begin
      fails++;
      $display("FAIL stall_hold valid=%b addr=%h want 1/30000", mem_valid, mem_addr);
    end
    mem_ready = 1'b1;
    end_load(seen, dr, bl);
    tests++;
    if (!seen || bl !== 16'd4 || nwr - w0 != 4 || sbq.size() != 0) begin
      fails++;
      $display("FAIL stall_drain seen=%0d bytes=%0d writes=%0d left=%0d want 1/4/4/0",
               seen, bl, nwr - w0, sbq.size());
    end
  endtask

  task automatic test_reset_midload();
    int dones;
    mem_ready = 1'b0;
    start_load(0);
    do_wr(15'h10, 8'h01);
    do_wr(15'h11, 8'h02);
    cyc();
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_valid !== 1'b0 || dut.state !== IDLE || cpu_reset_req !== 1'b0) begin
      fails++;
      $display("FAIL midload_reset valid=%b state=%0d crr=%b want 0/0/0",
               mem_valid, dut.state, cpu_reset_req);
    end
    cyc();
    cyc();
    ioctl_download = 1'b0;
    reset_n        = 1'b1;
    mem_ready      = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) dones++;
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL midload_no_done got=%0d want=0", dones);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    start_load(1);
    do_wr(15'h4000, 8'h33);
    ioctl_download = 1'b0;
    cyc();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    cyc();
    tests++;
    if (!seen || err_overflow !== 1'b0 || cpu_reset_req !== 1'b1 ||
        load_done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_relatch seen=%0d ovf=%b crr=%b done=%b want 1/0/1/0",
               seen, err_overflow, cpu_reset_req, load_done);
    end
    do_wr(15'h0003, 8'h77);
    end_load(seen, dr, bl);
    tests++;
    if (!seen || dr !== 2'd0 || bl !== 16'd1) begin
      fails++;
      $display("FAIL b2b_done seen=%0d region=%0d bytes=%0d want 1/0/1",
               seen, dr, bl);
    end
  endtask

  task automatic test_random();
    bit seen;
    logic [1:0] dr;
    logic [IN_AW:0] bl;
    int idx;
    int len;
    for (int n = 0; n < 8; n++) begin
      idx = $urandom_range(0, 4);
      start_load(idx);
      len = $urandom_range(8, 24);
      for (int c = 0; c < len; c++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        ioctl_wr  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       ioctl_addr = 15'($urandom_range(0, 31));
          1:       ioctl_addr = 15'($urandom_range('h3FF0, 'h400F));
          default: ioctl_addr = 15'($urandom);
        endcase
        ioctl_dout = 8'($urandom);
        cyc();
      end
      ioctl_wr  = 1'b0;
      mem_ready = 1'b1;
      end_load(seen, dr, bl);
      tests++;
      if (!seen || dr !== 2'((idx < NREG) ? idx : 0) || bl !== 16'(m_bytes)) begin
        fails++;
        $display("FAIL random_done n=%0d seen=%0d region=%0d bytes=%0d want region=%0d bytes=%0d",
                 n, seen, dr, bl, (idx < NREG) ? idx : 0, m_bytes);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    test_reset();
    reset_n = 1'b1;
    cyc();
    test_basic_load();
    test_single_write();
    test_unmapped();
    test_overflow();
    test_stall();
    test_reset_midload();
    test_back_to_back();
    test_random();
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
